// File: rtl/keccak_pkg.sv
// Shared Keccak-p[400] definitions: lane/plane/state types, round constants,
// rho offsets and flat <-> structured state conversion.
package keccak_pkg;

    localparam int N          = 16;
    localparam int STATE_SIZE = 25 * N;
    localparam int NUM_RC     = 20;

    // Packed so that state[y][x][z] sits at flat bit 16*(5y+x)+z.
    typedef logic [4:0][N-1:0] k_plane;
    typedef k_plane [4:0]      k_state;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } perm_fsm_e;

    // Low 16 bits of the 64-bit Keccak round constants RC[0..19].
    localparam logic [N-1:0] RC16 [NUM_RC] = '{
        16'h0001, 16'h8082, 16'h808A, 16'h8000, 16'h808B,
        16'h0001, 16'h8081, 16'h8009, 16'h008A, 16'h0088,
        16'h8009, 16'h000A, 16'h808B, 16'h008B, 16'h8089,
        16'h8003, 16'h8002, 16'h0080, 16'h800A, 16'h000A
    };

    // Indexed [y][x]; standard offsets already reduced mod 16.
    localparam int RHO_OFF [5][5] = '{
        '{ 0,  1, 14, 12, 11},
        '{ 4, 12,  6,  7,  4},
        '{ 3, 10, 11,  9,  7},
        '{ 9, 13, 15,  5,  8},
        '{ 2,  2, 13,  8, 14}
    };

    function automatic int NEG_MOD(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int r);
        logic [N-1:0] o;
        o = '0;
        for (int z = 0; z < N; z++) begin
            o[z] = v[NEG_MOD(z - r, N)];
        end
        return o;
    endfunction

    function automatic k_state to_keccak_state(input logic [STATE_SIZE-1:0] v);
        return k_state'(v);
    endfunction

    function automatic logic [STATE_SIZE-1:0] to_keccak_logic(input k_state s);
        return STATE_SIZE'(s);
    endfunction

endpackage

// File: rtl/keccak_round.sv
// One combinational Keccak-p[400] round (theta, rho, pi, chi, iota) for round index ir.
module keccak_round
    import keccak_pkg::*;
(
    input  k_state     state,
    input  logic [4:0] ir,
    output k_state     state_next
);

    k_plane       c;
    k_plane       d;
    k_state       theta;
    k_state       pi;
    k_state       chi;
    logic [N-1:0] rc;

    always_comb begin
        c     = '0;
        d     = '0;
        theta = '0;
        pi    = '0;
        chi   = '0;
        rc    = '0;

        for (int x = 0; x < 5; x++) begin
            c[x] = state[0][x] ^ state[1][x] ^ state[2][x] ^ state[3][x] ^ state[4][x];
        end
        for (int x = 0; x < 5; x++) begin
            d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                theta[y][x] = state[y][x] ^ d[x];
            end
        end
        // rho and pi fused: lane (x,y) moves to (y, 2x+3y).
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                pi[(2 * x + 3 * y) % 5][y] = rotl(theta[y][x], RHO_OFF[y][x]);
            end
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                chi[y][x] = pi[y][x] ^ (~pi[y][(x + 1) % 5] & pi[y][(x + 2) % 5]);
            end
        end
        // Indices past the last round select no constant.
        for (int i = 0; i < NUM_RC; i++) begin
            if (ir == 5'(i)) begin
                rc = RC16[i];
            end
        end

        state_next       = chi;
        state_next[0][0] = chi[0][0] ^ rc;
    end

endmodule

// File: rtl/keccak_p400_perm.sv
// Round-iterative Keccak-p[400, nr] core: applies the last nr rounds of
// Keccak-f[400], one round per clock, with a start/ready and valid/ack handshake.
module keccak_p400_perm
    import keccak_pkg::*;
#(
    parameter int MAX_ROUNDS = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [4:0]            nr_i,
    input  logic [STATE_SIZE-1:0] state_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [STATE_SIZE-1:0] state_o,
    input  logic                  ack_i
);

    perm_fsm_e  fsm_reg, fsm_next;
    logic [4:0] ir_reg, ir_next;
    k_state     state_reg, state_next;
    k_state     round_out;
    logic [4:0] nr_clamped;

    assign nr_clamped = (nr_i > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : nr_i;

    keccak_round u_round (
        .state      (state_reg),
        .ir         (ir_reg),
        .state_next (round_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg   <= IDLE;
            ir_reg    <= '0;
            state_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            ir_reg    <= ir_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        ir_next    = ir_reg;
        state_next = state_reg;

        unique case (fsm_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = to_keccak_state(state_i);
                    // Running the tail of the schedule: start at round 20-nr.
                    ir_next    = 5'(MAX_ROUNDS) - nr_clamped;
                    fsm_next   = (nr_clamped == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_next = round_out;
                ir_next    = ir_reg + 5'd1;
                if (ir_reg == 5'(MAX_ROUNDS - 1)) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (ack_i) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign ready_o = (fsm_reg == IDLE);
    assign valid_o = (fsm_reg == DONE);
    assign state_o = to_keccak_logic(state_reg);

endmodule

// File: tb/tb_keccak_p400_perm.sv
// Self-checking bench for keccak_p400_perm against an independent Keccak-p[400]
// model (rho offsets and round constants derived from their defining recurrences).
module tb_keccak_p400_perm;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [4:0]   nr_i;
    logic [399:0] state_i;
    logic         ready_o;
    logic         valid_o;
    logic [399:0] state_o;
    logic         ack_i;

    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [399:0] exp_q[$];
    int           lat_q[$];

    logic [399:0] s;
    logic [399:0] held;
    logic [399:0] dummy_state;
    int           dummy_lat;
    int           nr_list[6] = '{0, 1, 8, 12, 16, 20};

    always #5 clk_i = ~clk_i;

    keccak_p400_perm #(.MAX_ROUNDS(20)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .nr_i    (nr_i),
        .state_i (state_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .state_o (state_o),
        .ack_i   (ack_i)
    );

    task automatic check_eq(input string tag, input logic [399:0] got, input logic [399:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok %s", tag);
        end
    endtask

    function automatic logic [399:0] rand_state();
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < 13; i++) begin
            v = (v << 32) | 400'($urandom);
        end
        return v;
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
        int k;
        k = r % 16;
        if (k == 0) return v;
        return (v << k) | (v >> (16 - k));
    endfunction

    // Keccak rc(t) LFSR, x^8 + x^6 + x^5 + x^4 + 1.
    function automatic bit rc_bit(input int t);
        logic [8:0] r;
        r = 9'h001;
        for (int i = 1; i <= t % 255; i++) begin
            r = {r[7:0], 1'b0};
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
        end
        return r[0];
    endfunction

    function automatic logic [399:0] model_perm(input logic [399:0] st, input int nr);
        logic [15:0]  a[5][5];
        logic [15:0]  b[5][5];
        logic [15:0]  c[5];
        logic [15:0]  d[5];
        int           off[5][5];
        logic [15:0]  rc;
        logic [399:0] o;
        int           x, y, nx, n;
        n = (nr > 20) ? 20 : nr;
        for (int xx = 0; xx < 5; xx++)
            for (int yy = 0; yy < 5; yy++)
                a[xx][yy] = st[16 * (5 * yy + xx) +: 16];
        off[0][0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            off[x][y] = ((t + 1) * (t + 2) / 2) % 16;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
        for (int ir = 20 - n; ir < 20; ir++) begin
            for (int xx = 0; xx < 5; xx++)
                c[xx] = a[xx][0] ^ a[xx][1] ^ a[xx][2] ^ a[xx][3] ^ a[xx][4];
            for (int xx = 0; xx < 5; xx++)
                d[xx] = c[(xx + 4) % 5] ^ rol16(c[(xx + 1) % 5], 1);
            for (int xx = 0; xx < 5; xx++)
                for (int yy = 0; yy < 5; yy++)
                    a[xx][yy] = a[xx][yy] ^ d[xx];
            for (int xx = 0; xx < 5; xx++)
                for (int yy = 0; yy < 5; yy++)
                    b[yy][(2 * xx + 3 * yy) % 5] = rol16(a[xx][yy], off[xx][yy]);
            for (int xx = 0; xx < 5; xx++)
                for (int yy = 0; yy < 5; yy++)
                    a[xx][yy] = b[xx][yy] ^ (~b[(xx + 1) % 5][yy] & b[(xx + 2) % 5][yy]);
            rc = '0;
            for (int j = 0; j < 5; j++)
                rc[(1 << j) - 1] = rc_bit(j + 7 * ir);
            a[0][0] = a[0][0] ^ rc;
        end
        o = '0;
        for (int xx = 0; xx < 5; xx++)
            for (int yy = 0; yy < 5; yy++)
                o[16 * (5 * yy + xx) +: 16] = a[xx][yy];
        return o;
    endfunction

    // Called on a negedge; returns 1ns after the accept edge.
    task automatic start_perm(input string tag, input logic [399:0] st, input int nr);
        check_eq({tag, "_ready_before"}, 400'(ready_o), 400'(1));
        start_i = 1'b1;
        nr_i    = 5'(nr);
        state_i = st;
        exp_q.push_back(model_perm(st, nr));
        lat_q.push_back((nr > 20) ? 20 : nr);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        nr_i    = 5'($urandom);
        state_i = rand_state();
    endtask

    // Index 0 is the negedge right after the accept edge; valid must appear at index nr.
    task automatic wait_result(input string tag);
        int           cyc;
        int           lat;
        logic [399:0] exp;
        cyc = 0;
        @(negedge clk_i);
        while (!valid_o && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
        end
        lat = lat_q.pop_front();
        exp = exp_q.pop_front();
        check_eq({tag, "_latency"}, 400'(cyc), 400'(lat));
        check_eq({tag, "_state"}, state_o, exp);
        check_eq({tag, "_ready_low"}, 400'(ready_o), 400'(0));
    endtask

    task automatic ack_result(input string tag);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        check_eq({tag, "_ready_after_ack"}, 400'(ready_o), 400'(1));
        check_eq({tag, "_valid_after_ack"}, 400'(valid_o), 400'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        ack_i   = 1'b0;
        nr_i    = '0;
        state_i = '0;
        #1;
        check_eq("reset_ready", 400'(ready_o), 400'(1));
        check_eq("reset_valid", 400'(valid_o), 400'(0));
        check_eq("reset_state", state_o, '0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Zero state, one round: only iota of round 19 survives.
        start_perm("zero_nr1", '0, 1);
        wait_result("zero_nr1");
        check_eq("zero_nr1_const", state_o, {384'b0, 16'h000A});
        ack_result("zero_nr1");

        foreach (nr_list[i]) begin
            s = rand_state();
            start_perm($sformatf("rand_nr%0d", nr_list[i]), s, nr_list[i]);
            wait_result($sformatf("rand_nr%0d", nr_list[i]));
            if (nr_list[i] == 0) check_eq("nr0_passthrough", state_o, s);
            ack_result($sformatf("rand_nr%0d", nr_list[i]));
        end

        // Clamp: nr=25 must equal nr=20 in result and latency.
        s = rand_state();
        start_perm("clamp_nr20", s, 20);
        wait_result("clamp_nr20");
        ack_result("clamp_nr20");
        start_perm("clamp_nr25", s, 25);
        wait_result("clamp_nr25");
        check_eq("clamp_nr25_vs_nr20", state_o, model_perm(s, 20));
        ack_result("clamp_nr25");

        // Hold in DONE with start/state toggling: nothing may change.
        s    = rand_state();
        held = model_perm(s, 8);
        start_perm("hold", s, 8);
        wait_result("hold");
        for (int k = 0; k < 10; k++) begin
            start_i = 1'($urandom);
            nr_i    = 5'($urandom);
            state_i = rand_state();
            @(negedge clk_i);
            check_eq($sformatf("hold_state_%0d", k), state_o, held);
            check_eq($sformatf("hold_ready_%0d", k), 400'(ready_o), 400'(0));
        end
        start_i = 1'b0;
        ack_result("hold");
        @(negedge clk_i);
        check_eq("hold_no_second_accept", 400'(valid_o), 400'(0));
        check_eq("hold_state_kept", state_o, held);

        // Reset in the middle of an nr=20 run.
        s = rand_state();
        start_perm("midreset", s, 20);
        dummy_state = exp_q.pop_back();
        dummy_lat   = lat_q.pop_back();
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("midreset_state", state_o, '0);
        check_eq("midreset_valid", 400'(valid_o), 400'(0));
        check_eq("midreset_ready", 400'(ready_o), 400'(1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        s = rand_state();
        start_perm("after_reset_nr1", s, 1);
        wait_result("after_reset_nr1");
        ack_result("after_reset_nr1");

        check_eq("scoreboard_empty", 400'(exp_q.size()), 400'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
